// File: rtl/nes_bus_pkg.sv
// Shared definitions for the CPU bus: DMA FSM states and default bus addresses.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus signals around the OAM DMA arbiter.
// master: the DMA/arbiter block; slave: the CPU + memory decode environment.
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    output cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
  );

  modport slave (
    output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    input  cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA engine and CPU bus arbiter. A CPU write of page PP to DMA_REG_ADDR
// halts the CPU and copies PP00-PPFF to OAM_DATA_ADDR, one read/write pair per byte.
// Optional macro OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input logic       clk,
  input logic       reset,
  oam_dma_if.master dma_bus
);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;

  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        cpu_ready;
  logic        dma_active;

`ifdef OAM_DMA_ALIGN_EN
  logic odd_q;

  // Free-running cycle parity used to decide whether ALIGN is needed.
  always_ff @(posedge clk) begin
    if (!reset) odd_q <= 1'b0;
    else        odd_q <= ~odd_q;
  end
`endif

  // State, page, counter and read-data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic and bus multiplexer.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    bus_addr   = dma_bus.cpu_addr;
    bus_d_out  = dma_bus.cpu_d_out;
    bus_write  = 1'b0;
    cpu_ready  = 1'b0;
    dma_active = 1'b1;

    case (state_q)
      StIdle: begin
        cpu_ready  = 1'b1;
        dma_active = 1'b0;
        bus_write  = dma_bus.cpu_write;
        // The trigger write itself still reaches the bus.
        if (dma_bus.cpu_write && (dma_bus.cpu_addr == DMA_REG_ADDR)) begin
          page_d  = dma_bus.cpu_d_out;
          cnt_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = odd_q ? StAlign : StRead;
`else
        state_d = StRead;
`endif
      end
      StAlign: begin
        state_d = StRead;
      end
      StRead: begin
        bus_addr  = {page_q, cnt_q};
        bus_d_out = 8'h00;
        data_d    = dma_bus.bus_d_in;
        state_d   = StWrite;
      end
      StWrite: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = data_q;
        bus_write = 1'b1;
        // Source address never carries into the page; FF ends the copy.
        if (cnt_q == 8'hFF) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 8'h01;
          state_d = StRead;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dma_bus.bus_addr   = bus_addr;
  assign dma_bus.bus_d_out  = bus_d_out;
  assign dma_bus.bus_write  = bus_write;
  assign dma_bus.cpu_ready  = cpu_ready;
  assign dma_bus.dma_active = dma_active;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: pass-through, full copy, alignment, page FF,
// retrigger while busy and reset mid-copy.
module tb_oam_dma;

  logic clk;
  logic reset;
  bit   tb_odd;

  int n_vec;
  int n_err;

  oam_dma_if dif ();

  oam_dma dut (
    .clk     (clk),
    .reset   (reset),
    .dma_bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: byte at address a is a[7:0] ^ a[15:8] ^ A7, so page 02 holds i ^ A5.
  assign dif.bus_d_in = dif.bus_addr[7:0] ^ dif.bus_addr[15:8] ^ 8'hA7;

  // Expected cycle parity seen by the DUT.
  always @(posedge clk) begin
    if (!reset) tb_odd <= 1'b0;
    else        tb_odd <= ~tb_odd;
  end

  // Bus monitor.
  logic [7:0]  oam_data[$];
  logic [15:0] src_addr[$];
  logic [15:0] prev_addr;
  int          low_cnt;
  bit          zero_hit;

  always @(negedge clk) begin
    if (!dif.cpu_ready) low_cnt++;
    if (dif.bus_write && dif.bus_addr == 16'h2004) begin
      oam_data.push_back(dif.bus_d_out);
      src_addr.push_back(prev_addr);
    end
    if (dif.dma_active && dif.bus_addr == 16'h0000) zero_hit = 1'b1;
    prev_addr = dif.bus_addr;
  end

  // Trigger a DMA of page with the HALT cycle parity want_odd, optionally
  // retriggering or resetting at HALT-relative cycle k; waits for cpu_ready.
  task automatic run_dma(input logic [7:0] page, input bit want_odd,
                         input int retrig_k, input int reset_k, output bit done);
    done = 1'b0;
    @(posedge clk); #1;
    while (tb_odd == want_odd) begin
      @(posedge clk); #1;
    end
    oam_data.delete();
    src_addr.delete();
    low_cnt  = 0;
    zero_hit = 1'b0;
    dif.cpu_addr  = 16'h4014;
    dif.cpu_d_out = page;
    dif.cpu_write = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (dif.bus_write !== 1'b1 || dif.bus_addr !== 16'h4014 || dif.bus_d_out !== page) begin
      n_err++;
      $display("FAIL trigger_pass: got w=%b a=%h d=%h want w=1 a=4014 d=%h",
               dif.bus_write, dif.bus_addr, dif.bus_d_out, page);
    end
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        dif.cpu_write = 1'b0;
        dif.cpu_addr  = 16'h8000;
        dif.cpu_d_out = 8'h00;
      end
      if (k == retrig_k) begin
        dif.cpu_addr  = 16'h4014;
        dif.cpu_d_out = 8'h33;
        dif.cpu_write = 1'b1;
      end
      if (k == retrig_k + 1) begin
        dif.cpu_addr  = 16'h8000;
        dif.cpu_write = 1'b0;
      end
      if (k == reset_k)     reset = 1'b0;
      if (k == reset_k + 1) reset = 1'b1;
      @(negedge clk); #1;
      if (dif.cpu_ready) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL dma_timeout: cpu_ready still %b after 600 cycles, want 1", dif.cpu_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dif.cpu_addr  = 16'hBEEF;
    dif.cpu_d_out = 8'h11;
    dif.cpu_write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (dif.cpu_ready !== 1'b1 || dif.dma_active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ready=%b active=%b want ready=1 active=0",
               dif.cpu_ready, dif.dma_active);
    end
    n_vec++;
    if (dif.bus_addr !== 16'hBEEF || dif.bus_d_out !== 8'h11 || dif.bus_write !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pass: got a=%h d=%h w=%b want a=beef d=11 w=1",
               dif.bus_addr, dif.bus_d_out, dif.bus_write);
    end
    reset = 1'b1;
    dif.cpu_write = 1'b0;
  endtask

  task automatic test_passthrough();
    @(posedge clk); #1;
    dif.cpu_addr  = 16'h0123;
    dif.cpu_d_out = 8'h5A;
    dif.cpu_write = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dif.bus_addr !== 16'h0123 || dif.bus_d_out !== 8'h5A || dif.bus_write !== 1'b1 ||
        dif.cpu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pass_write: got a=%h d=%h w=%b rdy=%b want a=0123 d=5a w=1 rdy=1",
               dif.bus_addr, dif.bus_d_out, dif.bus_write, dif.cpu_ready);
    end
    // A read of the DMA register must not trigger.
    @(posedge clk); #1;
    dif.cpu_addr  = 16'h4014;
    dif.cpu_d_out = 8'h02;
    dif.cpu_write = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dif.bus_addr !== 16'h4014 || dif.bus_write !== 1'b0) begin
      n_err++;
      $display("FAIL pass_read: got a=%h w=%b want a=4014 w=0", dif.bus_addr, dif.bus_write);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (dif.cpu_ready !== 1'b1 || dif.dma_active !== 1'b0) begin
      n_err++;
      $display("FAIL read_no_trigger: got ready=%b active=%b want 1/0",
               dif.cpu_ready, dif.dma_active);
    end
  endtask

  task automatic test_full_copy();
    bit done;
    run_dma(8'h02, 1'b0, -10, -10, done);
    n_vec++;
    if (low_cnt != 513) begin
      n_err++;
      $display("FAIL copy_ready_low: got %0d cycles want 513", low_cnt);
    end
    n_vec++;
    if (oam_data.size() != 256) begin
      n_err++;
      $display("FAIL copy_count: got %0d writes want 256", oam_data.size());
    end
    for (int i = 0; i < oam_data.size() && i < 256; i++) begin
      n_vec++;
      if (oam_data[i] !== (8'hA5 ^ 8'(i)) || src_addr[i] !== (16'h0200 + 16'(i))) begin
        n_err++;
        $display("FAIL copy_byte%0d: got d=%h src=%h want d=%h src=%h", i, oam_data[i],
                 src_addr[i], 8'hA5 ^ 8'(i), 16'h0200 + 16'(i));
        break;
      end
    end
  endtask

  task automatic test_align();
    bit done;
    int want;
`ifdef OAM_DMA_ALIGN_EN
    want = 514;
`else
    want = 513;
`endif
    run_dma(8'h02, 1'b1, -10, -10, done);
    n_vec++;
    if (low_cnt != want) begin
      n_err++;
      $display("FAIL align_ready_low: got %0d cycles want %0d", low_cnt, want);
    end
    n_vec++;
    if (oam_data.size() != 256) begin
      n_err++;
      $display("FAIL align_count: got %0d writes want 256", oam_data.size());
    end
    for (int i = 0; i < oam_data.size() && i < 256; i++) begin
      n_vec++;
      if (oam_data[i] !== (8'hA5 ^ 8'(i))) begin
        n_err++;
        $display("FAIL align_byte%0d: got %h want %h", i, oam_data[i], 8'hA5 ^ 8'(i));
        break;
      end
    end
  endtask

  task automatic test_page_ff();
    bit done;
    run_dma(8'hFF, 1'b0, -10, -10, done);
    n_vec++;
    if (oam_data.size() != 256) begin
      n_err++;
      $display("FAIL ff_count: got %0d writes want 256", oam_data.size());
    end
    n_vec++;
    if (src_addr.size() > 0 && src_addr[src_addr.size()-1] !== 16'hFFFF) begin
      n_err++;
      $display("FAIL ff_last_src: got %h want ffff", src_addr[src_addr.size()-1]);
    end
    n_vec++;
    if (zero_hit) begin
      n_err++;
      $display("FAIL ff_wrap: got access to 0000 want none");
    end
    n_vec++;
    if (oam_data.size() > 255 && oam_data[255] !== 8'hA7) begin
      n_err++;
      $display("FAIL ff_last_data: got %h want a7", oam_data[255]);
    end
    @(negedge clk);
    n_vec++;
    if (dif.dma_active !== 1'b0 || dif.bus_addr !== 16'h8000) begin
      n_err++;
      $display("FAIL ff_idle: got active=%b a=%h want 0/8000", dif.dma_active, dif.bus_addr);
    end
  endtask

  task automatic test_retrigger();
    bit done;
    run_dma(8'h02, 1'b0, 21, -10, done);
    n_vec++;
    if (oam_data.size() != 256) begin
      n_err++;
      $display("FAIL retrig_count: got %0d writes want 256", oam_data.size());
    end
    for (int i = 0; i < src_addr.size() && i < 256; i++) begin
      n_vec++;
      if (src_addr[i] !== (16'h0200 + 16'(i)) || oam_data[i] !== (8'hA5 ^ 8'(i))) begin
        n_err++;
        $display("FAIL retrig_byte%0d: got src=%h d=%h want src=%h d=%h", i, src_addr[i],
                 oam_data[i], 16'h0200 + 16'(i), 8'hA5 ^ 8'(i));
        break;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    // Byte 100 is read in HALT-relative cycle 201; reset there aborts the copy.
    run_dma(8'h02, 1'b0, -10, 201, done);
    n_vec++;
    if (dif.cpu_ready !== 1'b1 || dif.dma_active !== 1'b0 || dif.bus_addr !== 16'h8000) begin
      n_err++;
      $display("FAIL rst_idle: got ready=%b active=%b a=%h want 1/0/8000",
               dif.cpu_ready, dif.dma_active, dif.bus_addr);
    end
    n_vec++;
    if (low_cnt != 202) begin
      n_err++;
      $display("FAIL rst_ready_low: got %0d cycles want 202", low_cnt);
    end
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (oam_data.size() != 100) begin
      n_err++;
      $display("FAIL rst_writes: got %0d writes want 100", oam_data.size());
    end
    // A fresh copy must start from byte 00.
    run_dma(8'h03, 1'b0, -10, -10, done);
    n_vec++;
    if (src_addr.size() == 0 || src_addr[0] !== 16'h0300 || oam_data[0] !== 8'hA4) begin
      n_err++;
      $display("FAIL rst_restart: got n=%0d first src=%h want n>0 src=0300 d=a4",
               src_addr.size(), src_addr.size() > 0 ? src_addr[0] : 16'h0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    dif.cpu_addr  = 16'h0000;
    dif.cpu_d_out = 8'h00;
    dif.cpu_write = 1'b0;
    test_reset();
    test_passthrough();
    test_full_copy();
    test_align();
    test_page_ff();
    test_retrigger();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
